multicycle_control_unit: RTL



---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the register-file/ALU datapath: latches an instruction on go and walks
// DECODE/READ/EXEC/WRITE/DONE. Define CU_SHIFT_EN to make opcodes 8 (SHL) and 9 (SHR) legal.
module multicycle_control_unit #(
  parameter  int WIDTH   = 16,
  parameter  int DEPTH   = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int INSTR_W = 4 + 3 * AW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic [INSTR_W-1:0] instr,
  output logic               WE,
  output logic               RE1,
  output logic               RE2,
  output logic [AW-1:0]      WA,
  output logic [AW-1:0]      RA1,
  output logic [AW-1:0]      RA2,
  output logic [1:0]         SEL1,
  output logic [1:0]         SEL2,
  output logic [2:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         state
);

  if (WIDTH < 1 || DEPTH < 2) begin : g_param_check
    $error("multicycle_control_unit: WIDTH must be >= 1 and DEPTH >= 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic          we;
    logic          re1;
    logic          re2;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [1:0]    sel1;
    logic [1:0]    sel2;
    logic [2:0]    alu_op;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    state;
  } ctrl_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  ctrl_t              ctrl_q;
  logic [3:0]         op_q;

  assign op_q = instr_q[INSTR_W-1 -: 4];

  // Register-register ops read both ports and run the ALU with operands straight from the file.
  function automatic logic is_rr(input logic [3:0] op);
`ifdef CU_SHIFT_EN
    return (op >= 4'd3) && (op <= 4'd9);
`else
    return (op >= 4'd3) && (op <= 4'd7);
`endif
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
`ifdef CU_SHIFT_EN
    return op >= 4'd10;
`else
    return op >= 4'd8;
`endif
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [2:0] code;
    case (op)
      4'd4:    code = 3'd1;
      4'd5:    code = 3'd2;
      4'd6:    code = 3'd3;
      4'd7:    code = 3'd4;
`ifdef CU_SHIFT_EN
      4'd8:    code = 3'd5;
      4'd9:    code = 3'd6;
`endif
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Moore decode of a state plus latched instruction; evaluated on the next-state values so the
  // outputs come straight from flops and line up with the state they describe.
  function automatic ctrl_t decode(input state_t s, input logic [INSTR_W-1:0] ins);
    logic [3:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic          rr, reads1, writes;
    ctrl_t         c;
    op     = ins[INSTR_W-1 -: 4];
    rd     = ins[3*AW-1 -: AW];
    rs1    = ins[2*AW-1 -: AW];
    rs2    = ins[AW-1:0];
    rr     = is_rr(op);
    reads1 = rr || (op == 4'd2);
    writes = reads1 || (op == 4'd1);
    c       = '0;
    c.state = s;
    c.busy  = (s != IDLE);
    if (s == READ || s == EXEC || s == WRITE) begin
      c.re1 = reads1;
      c.ra1 = reads1 ? rs1 : '0;
      c.re2 = rr;
      c.ra2 = rr ? rs2 : '0;
    end
    if (s == EXEC || s == WRITE) begin
      if (op == 4'd1) begin
        c.sel1 = 2'b10;
        c.sel2 = 2'b01;
      end else if (op == 4'd2) begin
        c.sel2 = 2'b01;
      end else if (rr) begin
        c.alu_op = alu_code(op);
      end
    end
    if (s == WRITE && writes) begin
      c.we = 1'b1;
      c.wa = rd;
    end
    if (s == DONE) begin
      c.done = 1'b1;
      c.err  = is_illegal(op);
    end
    return c;
  endfunction

  always_comb begin
    state_d = IDLE;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = DECODE;
          instr_d = instr;
        end
      end
      DECODE: begin
        if (op_q == 4'd0 || is_illegal(op_q)) state_d = DONE;
        else if (op_q == 4'd1)                state_d = EXEC;
        else                                  state_d = READ;
      end
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ctrl_q  <= decode(state_d, instr_d);
    end
  end

  assign WE     = ctrl_q.we;
  assign RE1    = ctrl_q.re1;
  assign RE2    = ctrl_q.re2;
  assign WA     = ctrl_q.wa;
  assign RA1    = ctrl_q.ra1;
  assign RA2    = ctrl_q.ra2;
  assign SEL1   = ctrl_q.sel1;
  assign SEL2   = ctrl_q.sel2;
  assign alu_op = ctrl_q.alu_op;
  assign busy   = ctrl_q.busy;
  assign done   = ctrl_q.done;
  assign err    = ctrl_q.err;
  assign state  = ctrl_q.state;

endmodule
